// File: rtl/mem_bank_pkg.sv
// Shared types for the per-bank exclusive-access adapter: request classification
// and the decode helper used by the top level.
package mem_bank_pkg;

   localparam int unsigned AtopWidth = 6;

   typedef enum logic [2:0] {
      REQ_ATOP,
      REQ_XLD,
      REQ_XST,
      REQ_WR,
      REQ_RD
   } req_class_t;

   // Atomics take priority over lock; lock splits into exclusive load/store.
   function automatic req_class_t classify(input logic [AtopWidth-1:0] atop,
                                           input logic lock,
                                           input logic we);
      req_class_t cls;
      if (atop != '0)      cls = REQ_ATOP;
      else if (lock && !we) cls = REQ_XLD;
      else if (lock)        cls = REQ_XST;
      else if (we)          cls = REQ_WR;
      else                  cls = REQ_RD;
      return cls;
   endfunction

endpackage

// File: rtl/mem_bank_excl_adapter_if.sv
// Bank-port bundle between the AXI-to-banked-memory converter (master) and the
// per-bank adapter (slave): request with lock/atop/id sidebands and response.
interface mem_bank_excl_adapter_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 4
);
   logic                   req_i;
   logic                   gnt_o;
   logic [AddrWidth-1:0]   req_addr_i;
   logic                   req_we_i;
   logic [DataWidth-1:0]   req_wdata_i;
   logic [DataWidth/8-1:0] req_strb_i;
   logic [5:0]             req_atop_i;
   logic                   req_lock_i;
   logic [IdWidth-1:0]     req_id_i;
   logic                   rvalid_o;
   logic [DataWidth-1:0]   rdata_o;
   logic                   err_o;
   logic                   exokay_o;

   modport master (
      output req_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i,
             req_atop_i, req_lock_i, req_id_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, exokay_o
   );

   modport slave (
      input  req_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i,
             req_atop_i, req_lock_i, req_id_i,
      output gnt_o, rvalid_o, rdata_o, err_o, exokay_o
   );
endinterface

// File: rtl/excl_rsv_table.sv
// Exclusive-access reservation table for one bank: lookup against the current
// contents, update (allocate / replace / clear) on the next edge.
module excl_rsv_table
   import mem_bank_pkg::*;
#(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned GranWidth = 26,
   parameter int unsigned NumRsv    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 op_valid_i,
   input  req_class_t           op_i,
   input  logic [IdWidth-1:0]   id_i,
   input  logic [GranWidth-1:0] gran_i,
   output logic                 hit_o
);
   localparam int unsigned PtrW = (NumRsv > 1) ? $clog2(NumRsv) : 1;

   // Entry layout depends on module parameters, so it lives here rather than in the package.
   typedef struct packed {
      logic                 valid;
      logic [IdWidth-1:0]   id;
      logic [GranWidth-1:0] gran;
   } rsv_entry_t;

   rsv_entry_t        table_reg  [NumRsv];
   rsv_entry_t        table_next [NumRsv];
   logic [PtrW-1:0]   vptr_reg, vptr_next;
   logic [NumRsv-1:0] id_match, gran_match, free;
   logic              id_any, free_any;
   logic [PtrW-1:0]   id_idx, free_idx;

   generate
      for (genvar gi = 0; gi < NumRsv; gi++) begin : g_match
         assign id_match[gi]   = table_reg[gi].valid && (table_reg[gi].id == id_i);
         assign gran_match[gi] = table_reg[gi].valid && (table_reg[gi].gran == gran_i);
         assign free[gi]       = !table_reg[gi].valid;
      end
   endgenerate

   assign hit_o = |(id_match & gran_match);

   // Descending scan leaves the lowest matching index.
   always_comb begin
      id_any   = 1'b0;
      id_idx   = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = NumRsv - 1; i >= 0; i--) begin
         if (id_match[i]) begin
            id_any = 1'b1;
            id_idx = PtrW'(i);
         end
         if (free[i]) begin
            free_any = 1'b1;
            free_idx = PtrW'(i);
         end
      end
   end

   always_comb begin
      table_next = table_reg;
      vptr_next  = vptr_reg;
      if (op_valid_i) begin
         case (op_i)
            REQ_XLD: begin
               if (id_any) begin
                  table_next[id_idx].gran = gran_i;
               end else if (free_any) begin
                  table_next[free_idx] = '{valid: 1'b1, id: id_i, gran: gran_i};
               end else begin
                  table_next[vptr_reg] = '{valid: 1'b1, id: id_i, gran: gran_i};
                  vptr_next = (vptr_reg == PtrW'(NumRsv - 1)) ? '0 : vptr_reg + 1'b1;
               end
            end
            REQ_XST: begin
               // A successful store kills every reservation on the granule;
               // a failed one only drops the requester's own reservation.
               for (int i = 0; i < NumRsv; i++) begin
                  if (hit_o ? gran_match[i] : id_match[i]) table_next[i].valid = 1'b0;
               end
            end
            REQ_WR: begin
               for (int i = 0; i < NumRsv; i++) begin
                  if (gran_match[i]) table_next[i].valid = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < NumRsv; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (rst_i) table_reg[gi] <= '0;
            else       table_reg[gi] <= table_next[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) vptr_reg <= '0;
      else       vptr_reg <= vptr_next;
   end

endmodule

// File: rtl/mem_bank_excl_adapter.sv
// Per-bank adapter: grants every request, drives the single-port SRAM, evaluates
// exclusive accesses against the reservation table and returns one response per grant.
module mem_bank_excl_adapter
   import mem_bank_pkg::*;
#(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned NumRsv      = 4,
   parameter int unsigned RsvGranLog2 = 6
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   mem_bank_excl_adapter_if.slave            bank,
   output logic                              sram_req_o,
   output logic                              sram_we_o,
   output logic [AddrWidth-$clog2(DataWidth/8)-1:0] sram_addr_o,
   output logic [DataWidth-1:0]              sram_wdata_o,
   output logic [DataWidth/8-1:0]            sram_be_o,
   input  logic [DataWidth-1:0]              sram_rdata_i
);
   localparam int unsigned OffW      = $clog2(DataWidth/8);
   localparam int unsigned GranWidth = AddrWidth - RsvGranLog2;

   req_class_t req_class;
   logic       xst_hit;
   logic       rvalid_reg, rvalid_next;
   logic       err_reg, err_next;
   logic       exokay_reg, exokay_next;
   logic       rd_flag_reg, rd_flag_next;

   assign req_class = classify(bank.req_atop_i, bank.req_lock_i, bank.req_we_i);

   excl_rsv_table #(
      .IdWidth   (IdWidth),
      .GranWidth (GranWidth),
      .NumRsv    (NumRsv)
   ) u_rsv_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .op_valid_i (bank.req_i),
      .op_i       (req_class),
      .id_i       (bank.req_id_i),
      .gran_i     (bank.req_addr_i[AddrWidth-1:RsvGranLog2]),
      .hit_o      (xst_hit)
   );

   assign bank.gnt_o   = bank.req_i;
   assign sram_we_o    = bank.req_we_i;
   assign sram_addr_o  = bank.req_addr_i[AddrWidth-1:OffW];
   assign sram_wdata_o = bank.req_wdata_i;
   assign sram_be_o    = bank.req_strb_i;

   // Atomics and failed exclusive stores never reach the SRAM.
   always_comb begin
      sram_req_o = 1'b0;
      if (bank.req_i) begin
         case (req_class)
            REQ_XLD, REQ_WR, REQ_RD: sram_req_o = 1'b1;
            REQ_XST:                 sram_req_o = xst_hit;
            default:                 sram_req_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      rvalid_next  = bank.req_i;
      err_next     = bank.req_i && (req_class == REQ_ATOP);
      exokay_next  = bank.req_i && ((req_class == REQ_XLD) ||
                                    ((req_class == REQ_XST) && xst_hit));
      rd_flag_next = bank.req_i && ((req_class == REQ_RD) || (req_class == REQ_XLD));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_reg  <= 1'b0;
         err_reg     <= 1'b0;
         exokay_reg  <= 1'b0;
         rd_flag_reg <= 1'b0;
      end else begin
         rvalid_reg  <= rvalid_next;
         err_reg     <= err_next;
         exokay_reg  <= exokay_next;
         rd_flag_reg <= rd_flag_next;
      end
   end

   assign bank.rvalid_o = rvalid_reg;
   assign bank.err_o    = err_reg;
   assign bank.exokay_o = exokay_reg;
   assign bank.rdata_o  = rd_flag_reg ? sram_rdata_i : '0;

endmodule

// File: tb/tb_mem_bank_excl_adapter.sv
// Bench for mem_bank_excl_adapter: directed vector table, reset-during-traffic
// sequence and randomized traffic against a behavioural reservation/memory model.
module tb_mem_bank_excl_adapter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int NR = 4;
   localparam int GL = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_mem;
   logic        sram_req, sram_we;
   logic [29:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata;
   logic [3:0]  sram_be;

   int n_checks = 0;
   int n_errors = 0;
   int txn = 0;

   mem_bank_excl_adapter_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bank_if ();

   mem_bank_excl_adapter #(
      .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .NumRsv(NR), .RsvGranLog2(GL)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bank         (bank_if),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_be_o    (sram_be),
      .sram_rdata_i (sram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM with one-cycle read latency.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | i);
      end else if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= mem[sram_addr[7:0]];
         end
      end
   end

   // Reference model: reservations as plain arrays, memory as a word array.
   bit          m_valid [NR];
   int          m_id    [NR];
   int          m_gran  [NR];
   int          m_vptr;
   logic [31:0] ref_mem [256];

   bit          exp_rv, exp_err, exp_exok;
   logic [31:0] exp_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (txn %0d)", name, act, req, txn);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
      m_vptr = 0;
   endtask

   task automatic model_write(input int word, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[word][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic model_op(input bit we, input bit lock, input logic [5:0] atop,
                           input int id, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb,
                           output bit sreq, output bit err, output bit exok,
                           output logic [31:0] rdata);
      int gran = int'(addr >> GL);
      int word = int'(addr[9:2]);
      int slot;
      bit hit;
      sreq = 1'b0; err = 1'b0; exok = 1'b0; rdata = '0;
      if (atop != 0) begin
         err = 1'b1;
      end else if (lock && !we) begin
         sreq = 1'b1; exok = 1'b1; rdata = ref_mem[word];
         slot = -1;
         for (int i = 0; i < NR; i++) if (m_valid[i] && m_id[i] == id) slot = i;
         for (int i = NR - 1; i >= 0 && slot < 0; i--) ;
         if (slot < 0) begin
            for (int i = 0; i < NR; i++) if (!m_valid[i] && slot < 0) slot = i;
         end
         if (slot < 0) begin
            slot = m_vptr;
            m_vptr = (m_vptr + 1) % NR;
         end
         m_valid[slot] = 1'b1; m_id[slot] = id; m_gran[slot] = gran;
      end else if (lock) begin
         hit = 1'b0;
         for (int i = 0; i < NR; i++) if (m_valid[i] && m_id[i] == id && m_gran[i] == gran) hit = 1'b1;
         if (hit) begin
            sreq = 1'b1; exok = 1'b1;
            model_write(word, wdata, strb);
            for (int i = 0; i < NR; i++) if (m_gran[i] == gran) m_valid[i] = 1'b0;
         end else begin
            for (int i = 0; i < NR; i++) if (m_id[i] == id) m_valid[i] = 1'b0;
         end
      end else if (we) begin
         sreq = 1'b1;
         model_write(word, wdata, strb);
         for (int i = 0; i < NR; i++) if (m_gran[i] == gran) m_valid[i] = 1'b0;
      end else begin
         sreq = 1'b1; rdata = ref_mem[word];
      end
   endtask

   // One clock cycle: check the response due now, drive a new request (or idle),
   // check the combinational SRAM side, then advance to just after the next edge.
   task automatic cycle(input bit r, input bit we, input bit lock, input logic [5:0] atop,
                        input logic [3:0] id, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit do_rst, output bit dut_sreq);
      bit          sreq, err, exok;
      logic [31:0] rdata;
      chk("rvalid", 64'(bank_if.rvalid_o), 64'(exp_rv));
      chk("err", 64'(bank_if.err_o), 64'(exp_err));
      chk("exokay", 64'(bank_if.exokay_o), 64'(exp_exok));
      chk("rdata", 64'(bank_if.rdata_o), 64'(exp_rdata));
      txn++;
      bank_if.req_i = r; bank_if.req_we_i = we; bank_if.req_lock_i = lock;
      bank_if.req_atop_i = atop; bank_if.req_id_i = id; bank_if.req_addr_i = addr;
      bank_if.req_wdata_i = wdata; bank_if.req_strb_i = strb;
      rst = do_rst;
      #1;
      chk("gnt", 64'(bank_if.gnt_o), 64'(r));
      sreq = 1'b0; err = 1'b0; exok = 1'b0; rdata = '0;
      if (r) model_op(we, lock, atop, int'(id), addr, wdata, strb, sreq, err, exok, rdata);
      dut_sreq = sram_req;
      chk("sram_req", 64'(sram_req), 64'(sreq));
      if (sreq) begin
         chk("sram_we", 64'(sram_we), 64'(we));
         chk("sram_addr", 64'(sram_addr), 64'(addr >> 2));
         chk("sram_be", 64'(sram_be), 64'(strb));
         if (we) chk("sram_wdata", 64'(sram_wdata), 64'(wdata));
      end
      $display("txn %0d: req=%0b we=%0b lock=%0b atop=%0h id=%0d addr=%0h rst=%0b -> sram_req=%0b err=%0b exokay=%0b",
               txn, r, we, lock, atop, id, addr, do_rst, sreq, err, exok);
      exp_rv = r; exp_err = err; exp_exok = exok; exp_rdata = rdata;
      if (do_rst) begin
         model_clear();
         exp_rv = 1'b0; exp_err = 1'b0; exp_exok = 1'b0; exp_rdata = '0;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          we, lock;
      logic [5:0]  atop;
      logic [3:0]  id;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
      bit          e_sreq, e_err, e_exok;
      bit          chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   function automatic vec_t mk(input bit we, input bit lock, input logic [5:0] atop,
                               input logic [3:0] id, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit es, input bit ee, input bit ex);
      vec_t v;
      v.we = we; v.lock = lock; v.atop = atop; v.id = id; v.addr = addr; v.wdata = wdata;
      v.strb = 4'hF; v.e_sreq = es; v.e_err = ee; v.e_exok = ex;
      v.chk_rd = 1'b0; v.e_rdata = '0;
      return v;
   endfunction

   vec_t vecs [17];

   initial begin
      bit          s;
      logic [31:0] a;
      vecs[0]  = mk(0, 0, 6'h00, 4'd3, 32'h040, 32'h0, 1, 0, 0);
      vecs[0].chk_rd = 1'b1; vecs[0].e_rdata = 32'hDEADBEEF;
      vecs[1]  = mk(0, 1, 6'h00, 4'd3, 32'h100, 32'h0, 1, 0, 1);
      vecs[2]  = mk(1, 1, 6'h00, 4'd3, 32'h104, 32'h11111111, 1, 0, 1);
      vecs[3]  = mk(1, 1, 6'h00, 4'd3, 32'h100, 32'h33333333, 0, 0, 0);
      vecs[4]  = mk(0, 1, 6'h00, 4'd1, 32'h100, 32'h0, 1, 0, 1);
      vecs[5]  = mk(1, 0, 6'h00, 4'd2, 32'h120, 32'h22222222, 1, 0, 0);
      vecs[6]  = mk(1, 1, 6'h00, 4'd1, 32'h100, 32'h44444444, 0, 0, 0);
      vecs[7]  = mk(0, 1, 6'h00, 4'd0, 32'h000, 32'h0, 1, 0, 1);
      vecs[8]  = mk(0, 1, 6'h00, 4'd1, 32'h040, 32'h0, 1, 0, 1);
      vecs[9]  = mk(0, 1, 6'h00, 4'd2, 32'h080, 32'h0, 1, 0, 1);
      vecs[10] = mk(0, 1, 6'h00, 4'd3, 32'h0C0, 32'h0, 1, 0, 1);
      vecs[11] = mk(0, 1, 6'h00, 4'd4, 32'h140, 32'h0, 1, 0, 1);
      vecs[12] = mk(1, 1, 6'h00, 4'd0, 32'h000, 32'h55555555, 0, 0, 0);
      vecs[13] = mk(1, 1, 6'h00, 4'd4, 32'h140, 32'h66666666, 1, 0, 1);
      vecs[14] = mk(0, 1, 6'h00, 4'd6, 32'h1C0, 32'h0, 1, 0, 1);
      vecs[15] = mk(1, 0, 6'h20, 4'd7, 32'h1C0, 32'h77777777, 0, 1, 0);
      vecs[15].chk_rd = 1'b1; vecs[15].e_rdata = '0;
      vecs[16] = mk(1, 1, 6'h00, 4'd6, 32'h1C0, 32'h88888888, 1, 0, 1);

      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | i);
      model_clear();
      exp_rv = 1'b0; exp_err = 1'b0; exp_exok = 1'b0; exp_rdata = '0;
      bank_if.req_i = 1'b0; bank_if.req_we_i = 1'b0; bank_if.req_lock_i = 1'b0;
      bank_if.req_atop_i = '0; bank_if.req_id_i = '0; bank_if.req_addr_i = '0;
      bank_if.req_wdata_i = '0; bank_if.req_strb_i = '0;
      rst = 1'b1; init_mem = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      init_mem = 1'b0;

      // Directed table: each row's response is checked right after its cycle.
      for (int i = 0; i < 17; i++) begin
         cycle(1, vecs[i].we, vecs[i].lock, vecs[i].atop, vecs[i].id, vecs[i].addr,
               vecs[i].wdata, vecs[i].strb, 0, s);
         chk($sformatf("tbl%0d_sram_req", i), 64'(s), 64'(vecs[i].e_sreq));
         chk($sformatf("tbl%0d_rvalid", i), 64'(bank_if.rvalid_o), 64'(1));
         chk($sformatf("tbl%0d_err", i), 64'(bank_if.err_o), 64'(vecs[i].e_err));
         chk($sformatf("tbl%0d_exokay", i), 64'(bank_if.exokay_o), 64'(vecs[i].e_exok));
         if (vecs[i].chk_rd)
            chk($sformatf("tbl%0d_rdata", i), 64'(bank_if.rdata_o), 64'(vecs[i].e_rdata));
      end

      // Reservation, then 8 back-to-back plain accesses with reset during the 5th.
      cycle(1, 0, 1, 6'h00, 4'd5, 32'h180, 32'h0, 4'hF, 0, s);
      for (int i = 0; i < 8; i++) begin
         a = 32'h200 + 32'(i * 4);
         cycle(1, i[0], 0, 6'h00, 4'(i), a, 32'hC0DE0000 | 32'(i), 4'hF, i == 4, s);
         if (i == 4) chk("rst_drop_rvalid", 64'(bank_if.rvalid_o), 64'(0));
         else        chk("b2b_rvalid", 64'(bank_if.rvalid_o), 64'(1));
      end
      cycle(1, 1, 1, 6'h00, 4'd5, 32'h180, 32'h99999999, 4'hF, 0, s);
      chk("post_rst_xst_sram_req", 64'(s), 64'(0));
      chk("post_rst_xst_exokay", 64'(bank_if.exokay_o), 64'(0));

      // Randomized traffic on a few granules so reservations collide often.
      for (int i = 0; i < 400; i++) begin
         bit          r, we, lock;
         logic [5:0]  atop;
         r    = ($urandom_range(0, 9) != 0);
         we   = $urandom_range(0, 1) == 1;
         lock = $urandom_range(0, 1) == 1;
         atop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
         a    = 32'($urandom_range(0, 5) * 64 + $urandom_range(0, 15) * 4);
         cycle(r, we, lock, atop, 4'($urandom_range(0, 5)), a, $urandom,
               4'($urandom_range(0, 15)), 0, s);
      end
      cycle(0, 0, 0, 6'h00, 4'd0, 32'h0, 32'h0, 4'h0, 0, s);
      cycle(0, 0, 0, 6'h00, 4'd0, 32'h0, 32'h0, 4'h0, 0, s);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
